// File: rtl/div_ctrl.sv
// Sequencer between the EX-stage signed DIV request and the multi-cycle divider core.
// Latches and freezes the operands, runs the div_begin handshake and produces a one-cycle HI/LO write.
module div_ctrl #(
    parameter logic [31:0] ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic        req_ready,
    input  logic        cancel,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        div_begin,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [31:0] div_result,
    input  logic [31:0] div_remainder,
    input  logic        div_end
);

    typedef enum logic [2:0] {IDLE, RUN, FIX, ZERO, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic        accept, capture, write_fix, write_zero;
    logic        div_begin_reg, out_valid_reg;
    logic [31:0] div_op1_reg, div_op2_reg;
    logic [31:0] q_raw_reg, r_raw_reg;
    logic [31:0] out_hi_reg, out_lo_reg;
    logic [31:0] hi_fix;

    // Core reports the remainder as a magnitude; it takes the sign of the dividend.
    assign hi_fix = div_op1_reg[31] ? (~r_raw_reg + 32'd1) : r_raw_reg;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        write_fix  = 1'b0;
        write_zero = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && !cancel) begin
                    accept     = 1'b1;
                    state_next = (req_op2 == 32'd0) ? ZERO : RUN;
                end
            end
            RUN: begin
                // A flush in the completion cycle still discards the result.
                if (cancel) begin
                    state_next = DRAIN;
                end else if (div_end) begin
                    capture    = 1'b1;
                    state_next = FIX;
                end
            end
            FIX: begin
                write_fix  = !cancel;
                state_next = IDLE;
            end
            ZERO: begin
                write_zero = !cancel;
                state_next = IDLE;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_begin_reg <= 1'b0;
            div_op1_reg   <= 32'd0;
            div_op2_reg   <= 32'd0;
            q_raw_reg     <= 32'd0;
            r_raw_reg     <= 32'd0;
            out_valid_reg <= 1'b0;
            out_hi_reg    <= 32'd0;
            out_lo_reg    <= 32'd0;
        end else begin
            state_reg     <= state_next;
            // Level stays high exactly while in RUN, so it drops on div_end and never restarts the core.
            div_begin_reg <= (state_next == RUN);
            out_valid_reg <= write_fix | write_zero;
            if (accept) begin
                div_op1_reg <= req_op1;
                div_op2_reg <= req_op2;
            end
            if (capture) begin
                q_raw_reg <= div_result;
                r_raw_reg <= div_remainder;
            end
            if (write_fix) begin
                out_hi_reg <= hi_fix;
                out_lo_reg <= q_raw_reg;
            end else if (write_zero) begin
                out_hi_reg <= div_op1_reg;
                out_lo_reg <= ZERO_LO;
            end
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign div_begin = div_begin_reg;
    assign div_op1   = div_op1_reg;
    assign div_op2   = div_op2_reg;
    assign out_valid = out_valid_reg;
    assign out_hi    = out_hi_reg;
    assign out_lo    = out_lo_reg;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer between the EX-stage DIV request and the multi-cycle signed `divider` core. It latches operands and holds them stable for the whole division. It drives the core's `div_begin` level protocol and samples the core outputs exactly on `div_end`. It applies MIPS remainder-sign correction, short-circuits divide-by-zero, supports pipeline cancel, and presents a one-cycle HI/LO write strobe.

## Interface
- `ZERO_LO`, default 32'hFFFF_FFFF: LO value written on divide-by-zero.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  EX stage issues signed DIV.
- `req_op1`  in  32  dividend (rs).
- `req_op2`  in  32  divisor (rt).
- `req_ready`  out  1  high only in IDLE; request accepted on edge with `req_valid & req_ready & ~cancel`.
- `cancel`  in  1  flush; aborts any in-flight operation and suppresses its write.
- `busy`  out  1  pipeline stall request; high in every state except IDLE.
- `out_valid`  out  1  one-cycle HI/LO write strobe.
- `out_hi`  out  32  remainder.
- `out_lo`  out  32  quotient.
- `div_begin`  out  1  registered level to core; high for the entire run.
- `div_op1`, `div_op2`  out  32 each  registered operands to core; constant while `div_begin` or core busy.
- `div_result`, `div_remainder`  in  32 each  core quotient (signed) / remainder magnitude.
- `div_end`  in  1  core completion; combinational from core, high one cycle.

## Operation
- States: IDLE, RUN, FIX, ZERO, DRAIN.
- IDLE: on accept with `req_op2 != 0`: latch `div_op1/div_op2`, set `div_begin`, go to RUN. On accept with `req_op2 == 0`: latch ops, go to ZERO, `div_begin` stays 0.
- RUN: hold `div_begin=1`; ops frozen, because the core re-reads operand signs during the run.
  - On edge with `div_end=1`: capture `q_raw=div_result`, `r_raw=div_remainder`, clear `div_begin`, go to FIX.
  - Core outputs are sampled only on that edge; they are not valid after it.
  - On `cancel`: clear `div_begin`, go to DRAIN, no capture.
- FIX: `out_lo<=q_raw`; `out_hi<= div_op1[31] ? (~r_raw+1) : r_raw` (remainder takes dividend sign). Pulse `out_valid`, go to IDLE. If `cancel` is high, suppress `out_valid` and the HI/LO update and go to IDLE.
- ZERO: `out_hi<=div_op1`, `out_lo<=ZERO_LO`, pulse `out_valid` (suppressed by `cancel`), go to IDLE.
- DRAIN: one cycle with `div_begin=0` so the core's valid flag clears, then go to IDLE.
- Overflow 0x8000_0000 / -1 is not trapped: LO=0x8000_0000, HI=0.
- Simultaneous `cancel` and `req_valid` in IDLE: cancel wins, request dropped, `req_ready` unchanged.
- `out_hi/out_lo` hold their last written value between strobes.

## Timing
- Reset (edge with `rst=1`, any state): state IDLE, `div_begin=0`, `div_op1=div_op2=0`, `out_valid=0`, `out_hi=out_lo=0`, `busy=0`, `req_ready=1`. Reset mid-RUN behaves as cancel toward the core. A request on the first edge after reset is legal.
- Accept at edge A. The core starts at A+1. The controller relies only on `div_end`, never on a cycle count; nominal `div_end` is about 35 cycles after A.
- `div_end` sampled at edge D gives `div_begin=0` from D on. `out_valid` is high in the cycle after edge D+1. State is IDLE in that same cycle, so a back-to-back request can be accepted while `out_valid` is high.
- Divide-by-zero: accept at A, `out_valid` high in the cycle after A+1.
- Cancel at edge C in RUN: `div_begin=0` after C, DRAIN, then IDLE after C+1. No `out_valid` is ever produced for a cancelled operation.
- `div_begin` never rises in the cycle immediately after a `div_end` edge, so the core never auto-restarts.

## Test plan
- 7 / -2 (0x7, 0xFFFF_FFFE) -> single `out_valid`: LO=0xFFFF_FFFD, HI=0x1; `busy` high from accept until the strobe cycle.
- -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF (core magnitude 1 is sign-corrected); 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- 100 / 0 -> no `div_begin` pulse, `out_valid` in the cycle after A+1 with HI=100, LO=0xFFFF_FFFF.
- 20 / 3 cancelled 10 cycles into RUN, then 20 / 3 reissued -> no strobe for the first; second gives LO=6, HI=2; `div_begin` low for at least 1 cycle between runs.
- Back-to-back: 9/4 then -9/4 issued in the `out_valid` cycle -> strobes LO=2,HI=1 then LO=0xFFFF_FFFE,HI=0xFFFF_FFFF; operands stable for the whole of each RUN.
- `rst` asserted mid-RUN, then a request 1/1 -> all outputs at reset values, then LO=1, HI=0, with no spurious strobe.
